// File: rtl/an_decoder_pipe_if.sv
// Stream bundle for an_decoder_pipe: codeword input side and decoded-word output side.
interface an_decoder_pipe_if #(
    parameter int AN_W = 9,
    parameter int N_W  = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [AN_W-1:0] ANe;
    logic            out_valid;
    logic            out_ready;
    logic [N_W-1:0]  Nc;
    logic            corrected;
    logic            uncorrectable;
    logic            err_range;

    modport master (
        output in_valid, ANe, out_ready,
        input  in_ready, out_valid, Nc, corrected, uncorrectable, err_range
    );

    modport slave (
        input  in_valid, ANe, out_ready,
        output in_ready, out_valid, Nc, corrected, uncorrectable, err_range
    );
endinterface

// File: rtl/an_decoder_pipe.sv
// Three-stage AN-code single-bit corrector/decoder with saturating statistics counters.
// Optional quotient range check and Nc saturation: define ANDEC_RANGE_CHECK_EN.
module an_decoder_pipe #(
    parameter int A     = 19,
    parameter int AN_W  = 9,
    parameter int N_W   = 4,
    parameter int MOD_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    an_decoder_pipe_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    typedef struct packed {
        logic [AN_W-1:0] anc;
        logic            corr;
        logic            uncorr;
    } fix_t;

    function automatic int pow2_mod(input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = (p * 2) % A;
        return p;
    endfunction

    // Entry k of the correction table: even k -> 2^(k/2) mod A, odd k -> A minus that.
    function automatic int tbl_val(input int k);
        return (k % 2 == 0) ? pow2_mod(k / 2) : A - pow2_mod(k / 2);
    endfunction

    function automatic bit params_ok();
        bit ok;
        ok = (A >= 3) && (A % 2 == 1) && ((longint'(1) << MOD_W) > longint'(A)) &&
             (longint'(A) * ((longint'(1) << N_W) - 1) < (longint'(1) << AN_W));
        for (int k = 0; k < 2 * AN_W; k++) begin
            if (tbl_val(k) == 0) ok = 1'b0;
            for (int j = k + 1; j < 2 * AN_W; j++)
                if (tbl_val(k) == tbl_val(j)) ok = 1'b0;
        end
        return ok;
    endfunction

    if (!params_ok()) begin : g_param_err
        $fatal(1, "an_decoder_pipe: illegal combination of A, AN_W, N_W, MOD_W");
    end

    function automatic logic [MOD_W-1:0] syndrome(input logic [AN_W-1:0] ane);
        return MOD_W'(ane % AN_W'(A));
    endfunction

    function automatic fix_t correct(input logic [AN_W-1:0] ane, input logic [MOD_W-1:0] syn);
        fix_t r;
        r.anc    = ane;
        r.corr   = 1'b0;
        r.uncorr = 1'b0;
        for (int i = 0; i < AN_W; i++) begin
            if (!r.corr && (syn == MOD_W'(pow2_mod(i)) || syn == MOD_W'(A - pow2_mod(i)))) begin
                r.anc  = ane ^ (AN_W'(1) << i);
                r.corr = 1'b1;
            end
        end
        r.uncorr = (syn != '0) && !r.corr;
        return r;
    endfunction

`ifdef ANDEC_RANGE_CHECK_EN
    // Returns {out_of_range, Nc}; Nc clamps to all-ones when the quotient overflows N_W bits.
    function automatic logic [N_W:0] div_sat(input logic [AN_W-1:0] anc);
        logic [AN_W-1:0] q;
        q = anc / AN_W'(A);
        if (q > AN_W'((1 << N_W) - 1)) return {1'b1, {N_W{1'b1}}};
        return {1'b0, q[N_W-1:0]};
    endfunction
`else
    function automatic logic [N_W-1:0] div_trunc(input logic [AN_W-1:0] anc);
        return N_W'(anc / AN_W'(A));
    endfunction
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    logic             adv, hs;
    fix_t             fix;
    logic             vld_p1_d, vld_p1_q;
    logic [AN_W-1:0]  ane_p1_d, ane_p1_q;
    logic [MOD_W-1:0] syn_p1_d, syn_p1_q;
    logic             vld_p2_d, vld_p2_q;
    logic [AN_W-1:0]  anc_p2_d, anc_p2_q;
    logic             corr_p2_d, corr_p2_q, uncorr_p2_d, uncorr_p2_q;
    logic             vld_p3_d, vld_p3_q;
    logic [N_W-1:0]   nc_p3_d, nc_p3_q;
    logic             corr_p3_d, corr_p3_q, uncorr_p3_d, uncorr_p3_q;
`ifdef ANDEC_RANGE_CHECK_EN
    logic             rng_p3_d, rng_p3_q;
    logic [N_W:0]     dq;
`endif
    logic [CNT_W-1:0] word_cnt_d, word_cnt_q, corr_cnt_d, corr_cnt_q;
    logic [CNT_W-1:0] uncorr_cnt_d, uncorr_cnt_q;

    always_comb begin
        adv          = !vld_p3_q || bus.out_ready;
        hs           = vld_p3_q && bus.out_ready;
        fix          = correct(ane_p1_q, syn_p1_q);
        vld_p1_d     = vld_p1_q;
        ane_p1_d     = ane_p1_q;
        syn_p1_d     = syn_p1_q;
        vld_p2_d     = vld_p2_q;
        anc_p2_d     = anc_p2_q;
        corr_p2_d    = corr_p2_q;
        uncorr_p2_d  = uncorr_p2_q;
        vld_p3_d     = vld_p3_q;
        nc_p3_d      = nc_p3_q;
        corr_p3_d    = corr_p3_q;
        uncorr_p3_d  = uncorr_p3_q;
`ifdef ANDEC_RANGE_CHECK_EN
        rng_p3_d     = rng_p3_q;
        dq           = div_sat(anc_p2_q);
`endif
        if (adv) begin
            // S1: capture codeword and syndrome
            vld_p1_d    = bus.in_valid;
            ane_p1_d    = bus.ANe;
            syn_p1_d    = syndrome(bus.ANe);
            // S2: corrected codeword; flags of empty slots forced low
            vld_p2_d    = vld_p1_q;
            anc_p2_d    = fix.anc;
            corr_p2_d   = vld_p1_q && fix.corr;
            uncorr_p2_d = vld_p1_q && fix.uncorr;
            // S3: quotient
            vld_p3_d    = vld_p2_q;
            corr_p3_d   = vld_p2_q && corr_p2_q;
            uncorr_p3_d = vld_p2_q && uncorr_p2_q;
`ifdef ANDEC_RANGE_CHECK_EN
            nc_p3_d     = dq[N_W-1:0];
            rng_p3_d    = vld_p2_q && dq[N_W];
`else
            nc_p3_d     = div_trunc(anc_p2_q);
`endif
        end
        word_cnt_d   = sat_inc(word_cnt_q, hs);
        corr_cnt_d   = sat_inc(corr_cnt_q, hs && corr_p3_q);
        uncorr_cnt_d = sat_inc(uncorr_cnt_q, hs && uncorr_p3_q);
        if (cnt_clr) begin
            word_cnt_d   = '0;
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        ane_p1_q <= ane_p1_d;
        syn_p1_q <= syn_p1_d;
        anc_p2_q <= anc_p2_d;
        if (rst) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            corr_p2_q    <= 1'b0;
            uncorr_p2_q  <= 1'b0;
            vld_p3_q     <= 1'b0;
            nc_p3_q      <= '0;
            corr_p3_q    <= 1'b0;
            uncorr_p3_q  <= 1'b0;
`ifdef ANDEC_RANGE_CHECK_EN
            rng_p3_q     <= 1'b0;
`endif
            word_cnt_q   <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            corr_p2_q    <= corr_p2_d;
            uncorr_p2_q  <= uncorr_p2_d;
            vld_p3_q     <= vld_p3_d;
            nc_p3_q      <= nc_p3_d;
            corr_p3_q    <= corr_p3_d;
            uncorr_p3_q  <= uncorr_p3_d;
`ifdef ANDEC_RANGE_CHECK_EN
            rng_p3_q     <= rng_p3_d;
`endif
            word_cnt_q   <= word_cnt_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.in_ready      = adv;
    assign bus.out_valid     = vld_p3_q;
    assign bus.Nc            = nc_p3_q;
    assign bus.corrected     = corr_p3_q;
    assign bus.uncorrectable = uncorr_p3_q;
`ifdef ANDEC_RANGE_CHECK_EN
    assign bus.err_range     = rng_p3_q;
`else
    assign bus.err_range     = 1'b0;
`endif
    assign word_cnt   = word_cnt_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule
